// File: rtl/lsu_data_mem_responder.sv
// LSU data-port memory responder: word RAM, reads answered after READ_LATENCY cycles with a one-cycle valid pulse.
// Writes always accepted; a read is held off while a write is requested in IDLE, otherwise the LSU stalls until valid.
module lsu_data_mem_responder #(
  parameter int unsigned DEPTH        = 1024,
  parameter int unsigned READ_LATENCY = 2,
  parameter logic [31:0] BASE_ADDR    = 32'h8000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] io_addr_i,
  input  logic        io_data_w_req,
  input  logic [31:0] io_data_w_i,
  input  logic        io_data_r_req,
  output logic [31:0] io_data_r_o,
  output logic        io_read_data_vaild,
  output logic        io_err_o
);

  localparam int unsigned AW        = $clog2(DEPTH);
  localparam logic [31:0] SPAN      = 32'(4 * DEPTH);
  localparam logic [3:0]  WAIT_INIT = 4'(READ_LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t        state, next_state;
  logic [3:0]    cnt, next_cnt;
  logic [AW-1:0] lat_idx;
  logic          lat_in_range;

  logic [31:0]   offset;
  logic [AW-1:0] idx;
  logic          in_range;
  logic          misaligned;
  logic          accept;
  logic          enter_resp;
  logic [AW-1:0] resp_idx;
  logic          resp_in_range;
  logic          err_set;

  logic [31:0]   mem [DEPTH];

  assign offset     = io_addr_i - BASE_ADDR;
  assign idx        = offset[AW+1:2];
  assign in_range   = (offset < SPAN);
  assign misaligned = (offset[1:0] != 2'b00);

  always_ff @(posedge clock) begin
    if (io_data_w_req && in_range) begin
      mem[idx] <= io_data_w_i;
    end
  end

  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    accept     = 1'b0;
    enter_resp = 1'b0;
    case (state)
      S_IDLE: begin
        // A write in the same cycle wins; the read is taken on a later edge.
        if (io_data_r_req && !io_data_w_req) begin
          accept = 1'b1;
          if (READ_LATENCY == 1) begin
            next_state = S_RESP;
            enter_resp = 1'b1;
          end else begin
            next_cnt   = WAIT_INIT;
            next_state = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        next_cnt = cnt - 4'd1;
        if (cnt == 4'd1) begin
          next_state = S_RESP;
          enter_resp = 1'b1;
        end
      end
      S_RESP: begin
        next_state = S_IDLE;
      end
      default: begin
        next_state = S_IDLE;
      end
    endcase
  end

  // With single-cycle latency the response is taken straight from the live decode.
  assign resp_idx      = (state == S_IDLE) ? idx : lat_idx;
  assign resp_in_range = (state == S_IDLE) ? in_range : lat_in_range;

  assign err_set = (io_data_w_req && (misaligned || !in_range))
                 | (accept && misaligned)
                 | (enter_resp && !resp_in_range);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state              <= S_IDLE;
      cnt                <= 4'd0;
      lat_idx            <= '0;
      lat_in_range       <= 1'b0;
      io_data_r_o        <= 32'h0000_0000;
      io_read_data_vaild <= 1'b0;
      io_err_o           <= 1'b0;
    end else begin
      state              <= next_state;
      cnt                <= next_cnt;
      io_read_data_vaild <= enter_resp;
      io_err_o           <= io_err_o | err_set;
      if (accept) begin
        lat_idx      <= idx;
        lat_in_range <= in_range;
      end
      if (enter_resp) begin
        io_data_r_o <= resp_in_range ? mem[resp_idx] : 32'h0000_0000;
      end
    end
  end

endmodule
